// File: rtl/trail_history_ctrl.sv
// Trail history ring: stores the last DEPTH tracker positions and streams them newest-first.
// Optional macro TRAIL_STALE_DECAY_EN: invalid frames drop the oldest entry.
module trail_history_ctrl #(
    parameter int DEPTH = 8,
    parameter int X_W   = 12,
    parameter int Y_W   = 11
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       nf_in,
    input  logic                       valid_in,
    input  logic [X_W-1:0]             x_in,
    input  logic [Y_W-1:0]             y_in,
    input  logic                       rd_start_in,
    input  logic                       entry_ready_in,
    output logic                       entry_valid_out,
    output logic [X_W-1:0]             entry_x_out,
    output logic [Y_W-1:0]             entry_y_out,
    output logic [$clog2(DEPTH)-1:0]   entry_age_out,
    output logic                       entry_last_out,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       busy_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t         state, state_nx;
    logic [X_W-1:0] mem_x [DEPTH];
    logic [Y_W-1:0] mem_y [DEPTH];
    logic [AW-1:0]  head, head_nx, snap_head, age, rd_ptr;
    logic [CW-1:0]  count, count_nx, snap_count;
    logic           pend_valid, pend_push;
    logic [X_W-1:0] pend_x, op_x;
    logic [Y_W-1:0] pend_y, op_y;
    logic           ev_now, op_push, op_decay, start, beat, last;

`ifdef TRAIL_STALE_DECAY_EN
    assign ev_now = nf_in;
`else
    assign ev_now = nf_in & valid_in;
`endif

    // Ring updates only happen in IDLE, so the ring is frozen for the whole stream.
    always_comb begin
        op_push  = 1'b0;
        op_decay = 1'b0;
        op_x     = x_in;
        op_y     = y_in;
        if (state == IDLE) begin
            if (pend_valid) begin
                op_push  = pend_push;
                op_decay = ~pend_push;
                op_x     = pend_x;
                op_y     = pend_y;
            end else begin
                op_push  = ev_now & valid_in;
                op_decay = ev_now & ~valid_in;
            end
        end
    end

    always_comb begin
        head_nx  = op_push ? head + 1'b1 : head;
        count_nx = count;
        if (op_push && count != CW'(DEPTH))
            count_nx = count + 1'b1;
        else if (op_decay && count != '0)
            count_nx = count - 1'b1;
    end

    assign start  = (state == IDLE) && rd_start_in && (count_nx != '0);
    assign beat   = (state == STREAM) && entry_ready_in;
    assign last   = (state == STREAM) && (CW'(age) == snap_count - 1'b1);
    assign rd_ptr = snap_head - age;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = STREAM;
            STREAM:  if (beat && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head       <= '0;
            count      <= '0;
            snap_head  <= '0;
            snap_count <= '0;
            age        <= '0;
            pend_valid <= 1'b0;
            pend_push  <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
        end else begin
            head  <= head_nx;
            count <= count_nx;
            if (start) begin
                snap_head  <= head_nx;
                snap_count <= count_nx;
                age        <= '0;
            end else if (beat) begin
                age <= last ? '0 : age + 1'b1;
            end
            // An event that cannot be applied this cycle replaces any held one.
            if (ev_now && (state == STREAM || pend_valid)) begin
                pend_valid <= 1'b1;
                pend_push  <= valid_in;
                pend_x     <= x_in;
                pend_y     <= y_in;
            end else if (state == IDLE) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (op_push) begin
            mem_x[head_nx] <= op_x;
            mem_y[head_nx] <= op_y;
        end
    end

    assign entry_valid_out = (state == STREAM);
    assign busy_out        = (state == STREAM);
    assign entry_x_out     = (state == STREAM) ? mem_x[rd_ptr] : '0;
    assign entry_y_out     = (state == STREAM) ? mem_y[rd_ptr] : '0;
    assign entry_age_out   = age;
    assign entry_last_out  = last;
    assign count_out       = count;

endmodule

// File: tb/tb_trail_history_ctrl.sv
// Directed self-checking bench for trail_history_ctrl (DEPTH=8, X_W=12, Y_W=11).
module tb_trail_history_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        nf_in = 1'b0, valid_in = 1'b0;
    logic [11:0] x_in = '0;
    logic [10:0] y_in = '0;
    logic        rd_start_in = 1'b0, entry_ready_in = 1'b0;
    logic        entry_valid_out, entry_last_out, busy_out;
    logic [11:0] entry_x_out;
    logic [10:0] entry_y_out;
    logic [2:0]  entry_age_out;
    logic [3:0]  count_out;

    int unsigned errors = 0;
    int unsigned checks = 0;

    trail_history_ctrl #(.DEPTH(8), .X_W(12), .Y_W(11)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .nf_in(nf_in), .valid_in(valid_in),
        .x_in(x_in), .y_in(y_in), .rd_start_in(rd_start_in), .entry_ready_in(entry_ready_in),
        .entry_valid_out(entry_valid_out), .entry_x_out(entry_x_out), .entry_y_out(entry_y_out),
        .entry_age_out(entry_age_out), .entry_last_out(entry_last_out),
        .count_out(count_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input int x, input int y, input int age, input int last);
        chk({tag, "_valid"}, 32'(entry_valid_out), 1);
        chk({tag, "_x"}, 32'(entry_x_out), 32'(x));
        chk({tag, "_y"}, 32'(entry_y_out), 32'(y));
        chk({tag, "_age"}, 32'(entry_age_out), 32'(age));
        chk({tag, "_last"}, 32'(entry_last_out), 32'(last));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, 32'(entry_valid_out), 0);
        chk({tag, "_busy"}, 32'(busy_out), 0);
    endtask

    task automatic push(input int x, input int y);
        nf_in = 1'b1; valid_in = 1'b1; x_in = 12'(x); y_in = 11'(y);
        tick();
        nf_in = 1'b0; valid_in = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        tick();
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_valid", 32'(entry_valid_out), 0);
        chk("rst_last", 32'(entry_last_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_x", 32'(entry_x_out), 0);
        chk("rst_y", 32'(entry_y_out), 0);
        chk("rst_age", 32'(entry_age_out), 0);
        tick();
        rst_n_in = 1'b1;
        tick();

        // three pushes, streamed with ready held high
        push(10, 20); push(11, 21); push(12, 22);
        chk("p3_count", 32'(count_out), 3);
        rd_start_in = 1'b1; entry_ready_in = 1'b1;
        tick();
        rd_start_in = 1'b0;
        beat("p3_b0", 12, 22, 0, 0);
        chk("p3_busy", 32'(busy_out), 1);
        tick(); beat("p3_b1", 11, 21, 1, 0);
        tick(); beat("p3_b2", 10, 20, 2, 1);
        tick(); idle_chk("p3_end");
        chk("p3_count_after", 32'(count_out), 3);

        // ten pushes wrap the ring; oldest two are overwritten
        do_reset();
        for (int k = 1; k <= 10; k++) push(k, k + 100);
        chk("w_count", 32'(count_out), 8);
        rd_start_in = 1'b1;
        tick();
        rd_start_in = 1'b0;
        for (int a = 0; a < 8; a++) begin
            beat($sformatf("w_b%0d", a), 10 - a, 110 - a, a, (a == 7) ? 1 : 0);
            tick();
        end
        idle_chk("w_end");

        // two-entry stream with ready toggling
        do_reset();
        entry_ready_in = 1'b0;
        push(1, 2); push(3, 4);
        rd_start_in = 1'b1;
        tick();
        rd_start_in = 1'b0;
        beat("st_a", 3, 4, 0, 0);
        tick(); beat("st_hold0", 3, 4, 0, 0);
        entry_ready_in = 1'b1;
        tick(); beat("st_b", 1, 2, 1, 1);
        entry_ready_in = 1'b0;
        tick(); beat("st_hold1", 1, 2, 1, 1);
        chk("st_busy_hold", 32'(busy_out), 1);
        entry_ready_in = 1'b1;
        tick(); idle_chk("st_end");

        // push during stream is held until the stream ends
        entry_ready_in = 1'b0;
        rd_start_in = 1'b1;
        tick();
        rd_start_in = 1'b0;
        beat("pd_a", 3, 4, 0, 0);
        push(50, 60);
        beat("pd_a_after_push", 3, 4, 0, 0);
        chk("pd_count_held", 32'(count_out), 2);
        entry_ready_in = 1'b1;
        tick(); beat("pd_b", 1, 2, 1, 1);
        tick(); idle_chk("pd_end");
        rd_start_in = 1'b1;
        tick();
        rd_start_in = 1'b0;
        chk("pd_count", 32'(count_out), 3);
        beat("pd_n0", 50, 60, 0, 0);
        tick(); beat("pd_n1", 3, 4, 1, 0);
        tick(); beat("pd_n2", 1, 2, 2, 1);
        tick(); idle_chk("pd_nend");
        chk("pd_count_final", 32'(count_out), 3);

        // empty ring ignores rd_start; simultaneous push+start gives a 1-entry stream
        do_reset();
        rd_start_in = 1'b1;
        tick(); idle_chk("e_ign0");
        tick(); idle_chk("e_ign1");
        nf_in = 1'b1; valid_in = 1'b1; x_in = 12'd7; y_in = 11'd8;
        tick();
        nf_in = 1'b0; valid_in = 1'b0; rd_start_in = 1'b0;
        beat("e_one", 7, 8, 0, 1);
        chk("e_count", 32'(count_out), 1);
        tick(); idle_chk("e_end");

`ifdef TRAIL_STALE_DECAY_EN
        push(20, 30); push(21, 31); push(22, 32);
        chk("d_count4", 32'(count_out), 4);
        for (int n = 0; n < 5; n++) begin
            nf_in = 1'b1; valid_in = 1'b0;
            tick();
            nf_in = 1'b0;
            chk($sformatf("d_count_%0d", n), 32'(count_out), (n < 4) ? 32'(3 - n) : 0);
            tick();
        end
`else
        // invalid frame leaves ring and count untouched
        nf_in = 1'b1; valid_in = 1'b0; x_in = 12'd99;
        tick();
        nf_in = 1'b0;
        chk("nv_count", 32'(count_out), 1);
        rd_start_in = 1'b1;
        tick();
        rd_start_in = 1'b0;
        beat("nv_b", 7, 8, 0, 1);
        tick(); idle_chk("nv_end");
`endif

        // asynchronous reset mid-stream
        entry_ready_in = 1'b0;
        push(9, 9);
        rd_start_in = 1'b1;
        tick();
        rd_start_in = 1'b0;
        chk("ar_valid_pre", 32'(entry_valid_out), 1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("ar_valid", 32'(entry_valid_out), 0);
        chk("ar_busy", 32'(busy_out), 0);
        chk("ar_count", 32'(count_out), 0);
        entry_ready_in = 1'b1;
        tick();
        rst_n_in = 1'b1;
        tick(); idle_chk("ar_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
